// File: rtl/color_blob_locator_pkg.sv
// Shared definitions for the colour-blob locator: raster defaults, RGB333
// field widths and the result FSM state encoding.
package color_blob_locator_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;
  localparam int CH_W         = 3;
  localparam int PIX_W        = 3 * CH_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DIV_X = 2'd2,
    ST_DIV_Y = 2'd3
  } state_t;

  // Only the bits set in mask take part in the comparison.
  function automatic logic rgb_match(input logic [PIX_W-1:0] pix,
                                     input logic [PIX_W-1:0] col,
                                     input logic [PIX_W-1:0] mask);
    return ((pix ^ col) & mask) == '0;
  endfunction

endpackage

// File: rtl/color_blob_locator_if.sv
// Pixel stream in, centroid result out.
// Handshake: the pixel stream has no flow control; every clock carries one
// sample at (hcount, vcount). On the result side loc_valid is a single-cycle
// pulse with no ready: x_loc/y_loc/found change only in the cycle loc_valid
// is high and hold otherwise. busy is high while a centroid division runs.
interface color_blob_locator_if;
  import color_blob_locator_pkg::*;

  logic [COORD_W-1:0] hcount;
  logic [COORD_W-1:0] vcount;
  logic [PIX_W-1:0]   pixel;
  logic               enable;
  logic [PIX_W-1:0]   color;
  logic [PIX_W-1:0]   color_mask;
  logic [COORD_W-1:0] x_loc;
  logic [COORD_W-1:0] y_loc;
  logic               found;
  logic               loc_valid;
  logic               busy;

  modport master (
    output hcount, vcount, pixel, enable, color, color_mask,
    input  x_loc, y_loc, found, loc_valid, busy
  );

  modport slave (
    input  hcount, vcount, pixel, enable, color, color_mask,
    output x_loc, y_loc, found, loc_valid, busy
  );

endinterface

// File: rtl/color_blob_locator_div.sv
// Restoring bit-serial divider. The start cycle already performs the first
// iteration on the incoming operands, so DW iterations occupy DW cycles and
// o_done pulses in the cycle after the last one.
module seq_divider #(
  parameter int DW = 28,
  parameter int VW = 19,
  parameter int QW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_done,
  output logic [QW-1:0] o_quotient
);
  localparam int CW = $clog2(DW + 1);

  logic [VW-1:0] r_rem;
  logic [DW-1:0] r_quo;
  logic [VW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic          r_done;

  logic [VW-1:0] w_rem_in;
  logic [DW-1:0] w_quo_in;
  logic [VW-1:0] w_div_in;
  logic [VW:0]   w_shift;
  logic          w_fits;
  logic [VW-1:0] w_diff;
  logic [VW-1:0] w_rem_nxt;
  logic [DW-1:0] w_quo_nxt;

  // One restoring step on either the fresh operands or the running state.
  always_comb begin
    w_rem_in  = i_start ? '0 : r_rem;
    w_quo_in  = i_start ? i_dividend : r_quo;
    w_div_in  = i_start ? i_divisor : r_div;
    w_shift   = {w_rem_in, w_quo_in[DW-1]};
    w_fits    = w_shift >= {1'b0, w_div_in};
    w_diff    = w_shift[VW-1:0] - w_div_in;
    w_rem_nxt = w_fits ? w_diff : w_shift[VW-1:0];
    w_quo_nxt = {w_quo_in[DW-2:0], w_fits};
  end

  // Iteration state and the done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_div <= w_div_in;
        r_cnt <= CW'(DW - 1);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo[QW-1:0];

endmodule

// File: rtl/color_blob_locator.sv
// Accumulates coordinates of pixels matching the masked target colour over a
// frame, then publishes the truncated centroid computed by one shared divider.
module color_blob_locator
  import color_blob_locator_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int MIN_PIXELS = 4,
  parameter int CNT_W      = 19,
  parameter int SUM_W      = 28
) (
  input  logic   clk,
  input  logic   reset_n,
  color_blob_locator_if.slave bus,
  output state_t o_dbg_state
);

  logic               w_active, w_hit, w_frame_end, w_enough;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SUM_W-1:0]   w_sx_nxt, w_sy_nxt, w_dividend;
  logic               w_div_start, w_div_done;
  logic [COORD_W-1:0] w_quo;
  state_t             w_next_state;

  logic [CNT_W-1:0]   r_acc_cnt, r_snap_cnt;
  logic [SUM_W-1:0]   r_acc_sx, r_acc_sy, r_snap_sx, r_snap_sy;
  state_t             r_state;
  logic [COORD_W-1:0] r_x_loc, r_y_loc, r_x_quo;
  logic               r_found, r_loc_valid;

  // Hit detection and the running totals including this cycle's hit.
  always_comb begin
    w_active    = (bus.hcount < COORD_W'(H_ACTIVE)) && (bus.vcount < COORD_W'(V_ACTIVE));
    w_hit       = w_active && bus.enable && rgb_match(bus.pixel, bus.color, bus.color_mask);
    w_frame_end = (bus.hcount == COORD_W'(H_ACTIVE - 1)) && (bus.vcount == COORD_W'(V_ACTIVE - 1));
    w_cnt_nxt   = r_acc_cnt + {{(CNT_W-1){1'b0}}, w_hit};
    w_sx_nxt    = r_acc_sx + (w_hit ? SUM_W'(bus.hcount) : '0);
    w_sy_nxt    = r_acc_sy + (w_hit ? SUM_W'(bus.vcount) : '0);
  end

  // Accumulators restart at frame end; the snapshot is only taken when idle
  // so a running division keeps its operands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc_cnt  <= '0;
      r_acc_sx   <= '0;
      r_acc_sy   <= '0;
      r_snap_cnt <= '0;
      r_snap_sx  <= '0;
      r_snap_sy  <= '0;
    end else if (w_frame_end) begin
      r_acc_cnt <= '0;
      r_acc_sx  <= '0;
      r_acc_sy  <= '0;
      if (r_state == ST_IDLE) begin
        r_snap_cnt <= w_cnt_nxt;
        r_snap_sx  <= w_sx_nxt;
        r_snap_sy  <= w_sy_nxt;
      end
    end else begin
      r_acc_cnt <= w_cnt_nxt;
      r_acc_sx  <= w_sx_nxt;
      r_acc_sy  <= w_sy_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state and divider launch: x starts in CHECK, y starts as x finishes.
  always_comb begin
    w_next_state = r_state;
    w_div_start  = 1'b0;
    w_dividend   = r_snap_sx;
    w_enough     = r_snap_cnt >= CNT_W'(MIN_PIXELS);
    case (r_state)
      ST_IDLE:  if (w_frame_end) w_next_state = ST_CHECK;
      ST_CHECK: begin
        if (w_enough) begin
          w_div_start  = 1'b1;
          w_next_state = ST_DIV_X;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DIV_X: begin
        if (w_div_done) begin
          w_div_start  = 1'b1;
          w_dividend   = r_snap_sy;
          w_next_state = ST_DIV_Y;
        end
      end
      ST_DIV_Y: if (w_div_done) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  seq_divider #(.DW(SUM_W), .VW(CNT_W), .QW(COORD_W)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (r_snap_cnt),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  // Result registers: x is parked until y is ready so both appear together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x_loc     <= '0;
      r_y_loc     <= '0;
      r_x_quo     <= '0;
      r_found     <= 1'b0;
      r_loc_valid <= 1'b0;
    end else begin
      r_loc_valid <= 1'b0;
      case (r_state)
        ST_CHECK: begin
          if (!w_enough) begin
            r_found     <= 1'b0;
            r_loc_valid <= 1'b1;
          end
        end
        ST_DIV_X: if (w_div_done) r_x_quo <= w_quo;
        ST_DIV_Y: begin
          if (w_div_done) begin
            r_x_loc     <= r_x_quo;
            r_y_loc     <= w_quo;
            r_found     <= 1'b1;
            r_loc_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.x_loc     = r_x_loc;
  assign bus.y_loc     = r_y_loc;
  assign bus.found     = r_found;
  assign bus.loc_valid = r_loc_valid;
  assign bus.busy      = ((r_state == ST_CHECK) && w_enough) ||
                         (r_state == ST_DIV_X) || (r_state == ST_DIV_Y);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_color_blob_locator.sv
// Small-raster bench for color_blob_locator with a frame-level centroid model.
module tb_color_blob_locator;
  import color_blob_locator_pkg::*;

  localparam int H    = 16;
  localparam int V    = 12;
  localparam int MINP = 4;
  localparam int CW   = 8;
  localparam int SW   = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  color_blob_locator_if bus();
  state_t dbg_state;

  color_blob_locator #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP), .CNT_W(CW), .SUM_W(SW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit started  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per frame: count, sum_x, sum_y. At an accepted frame end the result is
  // queued with the cycle it must appear in.
  int m_cnt, m_sx, m_sy, free_at, busy_lo, busy_hi;
  logic [20:0] exp_q[$];
  int          due_q[$];
  logic [9:0]  ex, ey;
  logic        ef;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_cnt = 0; m_sx = 0; m_sy = 0;
      exp_q.delete(); due_q.delete();
      ex = '0; ey = '0; ef = 1'b0;
      busy_lo = 1; busy_hi = 0; free_at = 0;
      started = 1;
    end else begin
      if (bus.hcount < H && bus.vcount < V && bus.enable &&
          ((bus.pixel ^ bus.color) & bus.color_mask) == 9'd0) begin
        m_cnt++;
        m_sx += int'(bus.hcount);
        m_sy += int'(bus.vcount);
      end
      if (bus.hcount == H-1 && bus.vcount == V-1) begin
        if (cyc >= free_at) begin
          if (m_cnt < MINP) begin
            exp_q.push_back({1'b0, ey, ex});
            due_q.push_back(cyc + 2);
            free_at = cyc + 2;
          end else begin
            exp_q.push_back({1'b1, 10'(m_sy / m_cnt), 10'(m_sx / m_cnt)});
            due_q.push_back(cyc + 2 + 2*SW);
            busy_lo = cyc + 1;
            busy_hi = cyc + 1 + 2*SW;
            free_at = cyc + 2 + 2*SW;
          end
        end
        m_cnt = 0; m_sx = 0; m_sy = 0;
      end
    end
    cyc++;
  end

  // ---------------- scoreboard compare ----------------
  logic exp_v, exp_b;
  always @(negedge clk) begin
    if (started) begin
      exp_v = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        {ef, ey, ex} = exp_q.pop_front();
        due_q.delete(0);
        exp_v = 1'b1;
      end
      exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
      check("loc_valid", 32'(bus.loc_valid), 32'(exp_v));
      check("busy",      32'(bus.busy),      32'(exp_b));
      check("found",     32'(bus.found),     32'(ef));
      check("x_loc",     32'(bus.x_loc),     32'(ex));
      check("y_loc",     32'(bus.y_loc),     32'(ey));
    end
  end

  // ---------------- driver tasks ----------------
  logic [8:0] img [V][H];

  task automatic clear_img();
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++) img[v][h] = 9'h000;
  endtask

  task automatic block_img();
    clear_img();
    for (int v = 3; v <= 6; v++)
      for (int h = 5; h <= 8; h++) img[v][h] = 9'h1C0;
  endtask

  task automatic drive(input int h, input int v, input logic [8:0] p);
    @(posedge clk); #1;
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    bus.pixel  = p;
  endtask

  task automatic set_blank();
    @(posedge clk); #1;
    bus.hcount = 10'(H + 3);
    bus.vcount = 10'(V + 1);
    bus.pixel  = 9'($urandom_range(0, 511));
  endtask

  // Raster with two blanking columns per line, ending on the frame-end pixel,
  // followed by one blanking cycle.
  task automatic run_frame(input bit rnd_en, output int fe);
    int last;
    last = (V-1)*(H+2) + (H-1);
    for (int i = 0; i <= last; i++) begin
      int h, v;
      h = i % (H+2);
      v = i / (H+2);
      @(posedge clk); #1;
      bus.hcount = 10'(h);
      bus.vcount = 10'(v);
      bus.pixel  = (h < H) ? img[v][h] : 9'($urandom_range(0, 511));
      if (rnd_en) bus.enable = ($urandom_range(0, 7) != 0);
    end
    fe = cyc;
    set_blank();
  endtask

  task automatic wait_result(input int fe, input int budget, output int got,
                             output int lat, output int fnd, output int x, output int y);
    got = 0; lat = -1; fnd = -1; x = -1; y = -1;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (bus.loc_valid === 1'b1) begin
        got = 1; lat = cyc - fe;
        fnd = int'(bus.found); x = int'(bus.x_loc); y = int'(bus.y_loc);
      end
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.loc_valid === 1'b1) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] masks [6];
  int fe, got, lat, fnd, x, y, n, r, thr;

  initial begin
    masks[0] = 9'h1FF; masks[1] = 9'h1C0; masks[2] = 9'h038;
    masks[3] = 9'h007; masks[4] = 9'h000; masks[5] = 9'h1F8;
    reset_n = 1'b0;
    bus.hcount = 10'(H + 3); bus.vcount = 10'(V + 1); bus.pixel = 9'h000;
    bus.enable = 1'b1; bus.color = 9'h1C0; bus.color_mask = 9'h1FF;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_x", 32'(bus.x_loc), 0);
    check("rst_y", 32'(bus.y_loc), 0);
    check("rst_found", 32'(bus.found), 0);
    check("rst_valid", 32'(bus.loc_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // 4x4 block -> centroid (6,4)
    block_img();
    run_frame(0, fe);
    wait_result(fe, 40, got, lat, fnd, x, y);
    check("t1_got", got, 1); check("t1_lat", lat, 2*SW+2);
    check("t1_found", fnd, 1); check("t1_x", x, 6); check("t1_y", y, 4);

    // no match -> fast not-found, position held
    clear_img();
    run_frame(0, fe);
    wait_result(fe, 40, got, lat, fnd, x, y);
    check("t2_got", got, 1); check("t2_lat", lat, 2);
    check("t2_found", fnd, 0); check("t2_x", x, 6); check("t2_y", y, 4);

    // masked match; frame-end pixel counted
    bus.color_mask = 9'h1C0;
    clear_img();
    img[V-1][H-1] = 9'h1FF;
    repeat (3) drive(0, 0, 9'h1FF);
    run_frame(0, fe);
    wait_result(fe, 40, got, lat, fnd, x, y);
    check("t3_lat", lat, 2*SW+2);
    check("t3_found", fnd, 1); check("t3_x", x, 3); check("t3_y", y, 2);

    // threshold: 3 vs 4 pixels
    clear_img();
    img[1][1] = 9'h1FF; img[2][2] = 9'h1FF; img[3][3] = 9'h1FF;
    run_frame(0, fe);
    wait_result(fe, 40, got, lat, fnd, x, y);
    check("t4a_found", fnd, 0); check("t4a_lat", lat, 2);
    img[9][10] = 9'h1FF;
    run_frame(0, fe);
    wait_result(fe, 40, got, lat, fnd, x, y);
    check("t4b_found", fnd, 1); check("t4b_x", x, 4); check("t4b_y", y, 3);

    // reset mid DIV_X
    bus.color_mask = 9'h1FF;
    block_img();
    run_frame(0, fe);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    count_valid(40, n);
    check("t5_no_valid", n, 0);
    check("t5_x", 32'(bus.x_loc), 0); check("t5_found", 32'(bus.found), 0);
    run_frame(0, fe);
    wait_result(fe, 40, got, lat, fnd, x, y);
    check("t5_found2", fnd, 1); check("t5_x2", x, 6); check("t5_y2", y, 4);

    // enable low -> not found; then frame end forced during busy
    bus.enable = 1'b0;
    run_frame(0, fe);
    wait_result(fe, 40, got, lat, fnd, x, y);
    check("t6_found", fnd, 0);
    bus.enable = 1'b1;
    run_frame(0, fe);
    repeat (2) @(posedge clk);
    drive(H-1, V-1, 9'h1C0);
    set_blank();
    count_valid(60, n);
    check("t6_one_valid", n, 1);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      bus.color      = 9'($urandom_range(0, 511));
      bus.color_mask = masks[$urandom_range(0, 5)];
      thr = $urandom_range(0, 6);
      for (int v = 0; v < V; v++)
        for (int h = 0; h < H; h++)
          img[v][h] = ($urandom_range(0, 9) < thr) ? bus.color : 9'($urandom_range(0, 511));
      run_frame(1, fe);
      r = $urandom_range(0, 5);
      if (r == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
      end else if (r == 1) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        drive(H-1, V-1, 9'($urandom_range(0, 511)));
        set_blank();
      end
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    bus.enable = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("drain_pending", due_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
